// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader port bundle: byte stream in, frame-buffer write port
// and status out. slave = loader side, master = driver side.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 17
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              err_chk;
  logic              err_timeout;
  logic              err_overrun;

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  cfg_base_addr,
    input  wr_ready,
    output wr_valid,
    output wr_addr,
    output wr_data,
    output busy,
    output frame_done,
    output err_chk,
    output err_timeout,
    output err_overrun
  );

  modport master (
    output rx_valid,
    output rx_data,
    output cfg_base_addr,
    output wr_ready,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  busy,
    input  frame_done,
    input  err_chk,
    input  err_timeout,
    input  err_overrun
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses SYNC/LEN/payload byte frames into frame-buffer writes.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module uart_frame_loader #(
  parameter int          ADDR_W      = 17,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input logic             clk_in,
  input logic             n_rst,
  uart_frame_loader_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_PAYLOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       remain_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              wr_valid_q;
  logic [TW-1:0]     timer_q;
  logic              done_q;
  logic              err_to_q;
  logic              err_ov_q;

  logic start;
  logic lat_hi;
  logic lat_lo;
  logic load;
  logic ovr;
  logic tmo;
  logic done;
  logic wr_acc;
  logic stall;
  logic rx_ok;
  logic timer_hit;

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       err_chk_q;
  logic       chk_bad;
`endif

  assign wr_acc    = wr_valid_q & bus.wr_ready;
  assign stall     = bus.rx_valid & wr_valid_q
                   & ~bus.wr_ready;
  assign rx_ok     = bus.rx_valid & ~stall;
  assign timer_hit = (timer_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    lat_hi  = 1'b0;
    lat_lo  = 1'b0;
    load    = 1'b0;
    ovr     = 1'b0;
    tmo     = 1'b0;
    done    = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    chk_bad = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid &&
            bus.rx_data == SYNC_BYTE) begin
          start   = 1'b1;
          state_d = S_LEN_H;
        end
      end
      S_LEN_H: begin
        if (rx_ok) begin
          lat_hi  = 1'b1;
          state_d = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (rx_ok) begin
          lat_lo = 1'b1;
          if ({len_hi_q, bus.rx_data} == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            done    = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_ok) begin
          load = 1'b1;
          if (remain_q == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_ok) begin
          state_d = S_IDLE;
          if (bus.rx_data == chk_q) begin
            done = 1'b1;
          end else begin
            chk_bad = 1'b1;
          end
        end
      end
`else
      // Last write must drain before the frame is reported complete.
      S_DONE: begin
        if (!wr_valid_q || wr_acc) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) begin
      if (stall) begin
        ovr     = 1'b1;
        state_d = S_IDLE;
      end else if (!bus.rx_valid &&
                   timer_hit && !done) begin
        tmo     = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      len_hi_q   <= '0;
      remain_q   <= '0;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      done_q <= done;
      if (start) begin
        addr_q   <= bus.cfg_base_addr;
        err_to_q <= 1'b0;
        err_ov_q <= 1'b0;
      end
      if (ovr) err_ov_q <= 1'b1;
      if (tmo) err_to_q <= 1'b1;
      if (lat_hi) len_hi_q <= bus.rx_data;
      if (lat_lo) remain_q <= {len_hi_q, bus.rx_data};
      if (load) begin
        wr_data_q <= bus.rx_data;
        wr_addr_q <= addr_q;
        addr_q    <= addr_q + ADDR_W'(1);
        remain_q  <= remain_q - 16'd1;
      end
      if (ovr || tmo) begin
        wr_valid_q <= 1'b0;
      end else if (load) begin
        wr_valid_q <= 1'b1;
      end else if (wr_acc) begin
        wr_valid_q <= 1'b0;
      end
      if (state_d == S_IDLE || bus.rx_valid) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      chk_q     <= '0;
      err_chk_q <= 1'b0;
    end else begin
      if (start) begin
        chk_q     <= '0;
        err_chk_q <= 1'b0;
      end
      if (load) chk_q <= chk_q ^ bus.rx_data;
      if (chk_bad) err_chk_q <= 1'b1;
    end
  end

  assign bus.err_chk = err_chk_q;
`else
  assign bus.err_chk = 1'b0;
`endif

  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.frame_done  = done_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_overrun = err_ov_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Random and directed frames for uart_frame_loader against a
// queue-based model of the expected frame-buffer writes.
module tb_uart_frame_loader;

  localparam int AW = 17;
  localparam int TO = 50;

  logic clk_in = 1'b0;
  logic n_rst  = 1'b0;

  always #5 clk_in = ~clk_in;

  uart_frame_loader_if #(.ADDR_W(AW)) bus ();

  uart_frame_loader #(
    .ADDR_W     (AW),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_in(clk_in),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int nvec     = 0;
  int nerr     = 0;
  int done_cnt = 0;
  int rdy_mode = 0;

  logic [AW+7:0] act_q[$];
  logic [AW+7:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (n_rst && bus.wr_valid && bus.wr_ready)
      act_q.push_back({bus.wr_addr, bus.wr_data});
    if (bus.frame_done) begin
      done_cnt++;
      check("done_wv", 32'(bus.wr_valid), 32'd0);
    end
  end

  function automatic logic [31:0] outs();
    return {bus.wr_valid, bus.busy, bus.frame_done,
            bus.err_chk, bus.err_timeout,
            bus.err_overrun, bus.wr_data,
            bus.wr_addr};
  endfunction

  task automatic set_ready();
    case (rdy_mode)
      0:       bus.wr_ready = 1'($urandom_range(0, 1));
      1:       bus.wr_ready = 1'b1;
      default: bus.wr_ready = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      bus.rx_valid = 1'b0;
      set_ready();
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk_in);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (rdy_mode != 2) bus.wr_ready = 1'b1;
    @(posedge clk_in);
    #1;
    bus.rx_valid = 1'b0;
    set_ready();
  endtask

  task automatic drain();
    int m;
    m        = rdy_mode;
    rdy_mode = 1;
    idle(4);
    rdy_mode = m;
    @(negedge clk_in);
  endtask

  task automatic check_frame(input string tag,
                             input int done0,
                             input int exp_done,
                             input logic exp_chk);
    int n;
    check({tag, "_nwr"}, 32'(act_q.size()),
          32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ?
        act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i),
            32'(act_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done_cnt - done0),
          32'(exp_done));
    check({tag, "_st"},
          {26'd0, bus.busy, bus.wr_valid,
           bus.err_chk, bus.err_timeout,
           bus.err_overrun, 1'b0},
          {29'd0, exp_chk, 2'b00});
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag,
                           input logic [AW-1:0] base,
                           input int len,
                           input bit bad);
    logic [7:0]    b;
    logic [7:0]    x;
    logic [15:0]   l;
    logic [AW-1:0] a;
    int            d0;
    int            exp_done;
    logic          exp_chk;
    d0 = done_cnt;
    l  = 16'(len);
    bus.cfg_base_addr = base;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send(b);
      idle($urandom_range(0, 3));
    end
    send(8'hA5);
    idle($urandom_range(0, 4));
    send(l[15:8]);
    idle($urandom_range(0, 4));
    send(l[7:0]);
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      a = base + AW'(i);
      exp_q.push_back({a, b});
      idle($urandom_range(0, 4));
      send(b);
    end
    exp_done = 1;
    exp_chk  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    idle($urandom_range(0, 4));
    send(bad ? ~x : x);
    if (bad) begin
      exp_done = 0;
      exp_chk  = 1'b1;
    end
`else
    if (bad) begin
      drain();
      send(8'h34);
    end
`endif
    drain();
    check_frame(tag, d0, exp_done, exp_chk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [AW-1:0] base;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.wr_ready      = 1'b0;
    bus.cfg_base_addr = '0;
    #12;
    check("reset", outs(), 32'd0);
    @(negedge clk_in);
    n_rst = 1'b1;

    // Directed frame with latency probe on the first write.
    d0 = done_cnt;
    rdy_mode = 2;
    bus.cfg_base_addr = 17'h00100;
    send(8'hA5);
    send(8'h00);
    send(8'h03);
    send(8'h11);
    @(negedge clk_in);
    check("latency",
          {7'd0, bus.wr_valid, bus.wr_addr, bus.wr_data},
          {7'd0, 1'b1, 17'h00100, 8'h11});
    rdy_mode = 1;
    send(8'h22);
    send(8'h33);
`ifdef UART_LOADER_CHECKSUM_EN
    send(8'h11 ^ 8'h22 ^ 8'h33);
`endif
    exp_q.push_back({17'h00100, 8'h11});
    exp_q.push_back({17'h00101, 8'h22});
    exp_q.push_back({17'h00102, 8'h33});
    drain();
    check_frame("t1", d0, 1, 1'b0);

    // Overrun: second byte while the first write is stalled.
    d0 = done_cnt;
    rdy_mode = 2;
    bus.cfg_base_addr = '0;
    send(8'hA5);
    send(8'h00);
    send(8'h05);
    send(8'h11);
    send(8'h22);
    @(negedge clk_in);
    check("ovr_st",
          {27'd0, bus.busy, bus.wr_valid,
           bus.err_overrun, bus.err_timeout,
           bus.err_chk},
          {27'd0, 5'b00100});
    check("ovr_nwr", 32'(act_q.size()), 32'd0);
    check("ovr_done", 32'(done_cnt - d0), 32'd0);

    // Timeout after LEN_L with no payload.
    rdy_mode = 1;
    send(8'hA5);
    check("ovr_clr", 32'(bus.err_overrun), 32'd0);
    send(8'h00);
    send(8'h05);
    @(negedge clk_in);
    repeat (TO - 1) @(negedge clk_in);
    check("to_pre",
          {30'd0, bus.busy, bus.err_timeout},
          {30'd0, 2'b10});
    @(negedge clk_in);
    check("to_hit",
          {30'd0, bus.busy, bus.err_timeout},
          {30'd0, 2'b01});

    rdy_mode = 0;
    run_frame("wrap", 17'h1FFFF, 2, 1'b0);

    // Reset while a write is pending mid-payload.
    rdy_mode = 2;
    bus.cfg_base_addr = 17'h00040;
    send(8'hA5);
    send(8'h00);
    send(8'h04);
    send(8'h55);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_mid", outs(), 32'd0);
    @(negedge clk_in);
    check("rst_hold", outs(), 32'd0);
    n_rst = 1'b1;
    check("rst_nwr", 32'(act_q.size()), 32'd0);
    act_q.delete();
    rdy_mode = 0;
    run_frame("after_rst", 17'h00040, 4, 1'b0);

    run_frame("len0", 17'h00200, 0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0)
        base = 17'h1FFFF - AW'($urandom_range(0, 4));
      else
        base = AW'($urandom);
      run_frame($sformatf("rnd%0d", f), base,
                $urandom_range(0, 9),
                ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
